// File: rtl/rs_issue_scheduler_if.sv
// Handshake bundle between the reservation-station table / FU array and the issue scheduler.
interface rs_issue_scheduler_if #(
  parameter int NUM_RS = 64,
  parameter int IDX_W  = 6
);
  logic [NUM_RS-1:0] rs_valid;
  logic [NUM_RS-1:0] rs_ready;
  logic [NUM_RS-1:0] rs_is_mem;
  logic              flush;
  logic              mem_stall;
  logic [2:0]        issue_valid;
  logic [IDX_W-1:0]  issue_idx0;
  logic [IDX_W-1:0]  issue_idx1;
  logic [IDX_W-1:0]  issue_idx2;
  logic [NUM_RS-1:0] rs_clear;
  logic [2:0]        fu_busy;
  logic [15:0]       issue_count;

  modport master (
    output rs_valid, rs_ready, rs_is_mem, flush, mem_stall,
    input  issue_valid, issue_idx0, issue_idx1, issue_idx2, rs_clear, fu_busy, issue_count
  );

  modport slave (
    input  rs_valid, rs_ready, rs_is_mem, flush, mem_stall,
    output issue_valid, issue_idx0, issue_idx1, issue_idx2, rs_clear, fu_busy, issue_count
  );
endinterface

// File: rtl/rs_issue_scheduler.sv
// Select-and-issue scheduler: round-robin pick of ready RS entries onto two ALUs and one memory FU,
// with registered issue outputs, per-FU occupancy counters and a running issue counter.
module rs_issue_scheduler #(
  parameter int NUM_RS  = 64,
  parameter int IDX_W   = 6,
  parameter int ALU_LAT = 1,
  parameter int MEM_LAT = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rs_issue_scheduler_if.slave  bus
);
  localparam int CNT_W = 8;

  logic [IDX_W-1:0]  alu_ptr_reg, alu_ptr_next;
  logic [IDX_W-1:0]  mem_ptr_reg, mem_ptr_next;
  logic [2:0]        issue_valid_reg, issue_valid_next;
  logic [IDX_W-1:0]  idx_reg [3];
  logic [IDX_W-1:0]  idx_next [3];
  logic [NUM_RS-1:0] rs_clear_reg, rs_clear_next;
  logic [CNT_W-1:0]  occ_reg [3];
  logic [CNT_W-1:0]  occ_next [3];
  logic [15:0]       count_reg, count_next;

  logic [NUM_RS-1:0] cand, alu_rot, mem_rot;
  logic [2:0]        fu_free, sel;
  logic              a_hit0, a_hit1, m_hit;
  logic [IDX_W-1:0]  a_off0, a_off1, m_off;
  logic [IDX_W-1:0]  a_idx0, a_idx1, m_idx;
  logic [1:0]        pop;

  // Entries still being retired by the RS table are masked so they cannot issue twice.
  assign cand = bus.rs_valid & bus.rs_ready & ~rs_clear_reg;

  // Rotate each class vector so bit 0 is the entry at its scan pointer.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_RS; gi++) begin : g_rot
      logic [IDX_W-1:0] a_pos, m_pos;
      assign a_pos       = alu_ptr_reg + IDX_W'(gi);
      assign m_pos       = mem_ptr_reg + IDX_W'(gi);
      assign alu_rot[gi] = cand[a_pos] & ~bus.rs_is_mem[a_pos];
      assign mem_rot[gi] = cand[m_pos] & bus.rs_is_mem[m_pos];
    end
  endgenerate

  always_comb begin
    a_hit0 = 1'b0;
    a_hit1 = 1'b0;
    m_hit  = 1'b0;
    a_off0 = '0;
    a_off1 = '0;
    m_off  = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      if (alu_rot[i]) begin
        if (!a_hit0) begin
          a_hit0 = 1'b1;
          a_off0 = IDX_W'(i);
        end else if (!a_hit1) begin
          a_hit1 = 1'b1;
          a_off1 = IDX_W'(i);
        end
      end
      if (mem_rot[i] && !m_hit) begin
        m_hit = 1'b1;
        m_off = IDX_W'(i);
      end
    end
  end

  always_comb begin
    sel    = 3'b000;
    a_idx0 = alu_ptr_reg + a_off0;
    a_idx1 = alu_ptr_reg + a_off1;
    m_idx  = mem_ptr_reg + m_off;
    if (!bus.flush) begin
      if (fu_free[0]) begin
        sel[0] = a_hit0;
        sel[1] = a_hit1 & fu_free[1];
      end else if (fu_free[1]) begin
        sel[1] = a_hit0;
        a_idx1 = a_idx0;
      end
      sel[2] = m_hit & fu_free[2] & ~bus.mem_stall;
    end
  end

  always_comb begin
    issue_valid_next = sel;
    idx_next[0]      = sel[0] ? a_idx0 : idx_reg[0];
    idx_next[1]      = sel[1] ? a_idx1 : idx_reg[1];
    idx_next[2]      = sel[2] ? m_idx  : idx_reg[2];
    rs_clear_next    = '0;
    if (sel[0]) rs_clear_next[a_idx0] = 1'b1;
    if (sel[1]) rs_clear_next[a_idx1] = 1'b1;
    if (sel[2]) rs_clear_next[m_idx]  = 1'b1;
    // FU1 always holds the later entry in scan order when it issues.
    alu_ptr_next = alu_ptr_reg;
    if (sel[1])      alu_ptr_next = a_idx1 + IDX_W'(1);
    else if (sel[0]) alu_ptr_next = a_idx0 + IDX_W'(1);
    mem_ptr_next = sel[2] ? m_idx + IDX_W'(1) : mem_ptr_reg;
    pop          = {1'b0, sel[0]} + {1'b0, sel[1]} + {1'b0, sel[2]};
    count_next   = count_reg + {14'd0, pop};
  end

  generate
    for (gi = 0; gi < 3; gi++) begin : g_occ
      localparam int LAT = (gi == 2) ? MEM_LAT : ALU_LAT;
      assign fu_free[gi]     = (occ_reg[gi] == '0);
      assign bus.fu_busy[gi] = ~fu_free[gi];
      always_comb begin
        occ_next[gi] = '0;
        if (bus.flush)         occ_next[gi] = '0;
        else if (sel[gi])      occ_next[gi] = CNT_W'(LAT - 1);
        else if (!fu_free[gi]) occ_next[gi] = occ_reg[gi] - CNT_W'(1);
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_ptr_reg     <= '0;
      mem_ptr_reg     <= '0;
      issue_valid_reg <= '0;
      rs_clear_reg    <= '0;
      count_reg       <= '0;
      for (int k = 0; k < 3; k++) begin
        idx_reg[k] <= '0;
        occ_reg[k] <= '0;
      end
    end else begin
      alu_ptr_reg     <= alu_ptr_next;
      mem_ptr_reg     <= mem_ptr_next;
      issue_valid_reg <= issue_valid_next;
      rs_clear_reg    <= rs_clear_next;
      count_reg       <= count_next;
      for (int k = 0; k < 3; k++) begin
        idx_reg[k] <= idx_next[k];
        occ_reg[k] <= occ_next[k];
      end
    end
  end

  assign bus.issue_valid = issue_valid_reg;
  assign bus.issue_idx0  = idx_reg[0];
  assign bus.issue_idx1  = idx_reg[1];
  assign bus.issue_idx2  = idx_reg[2];
  assign bus.rs_clear    = rs_clear_reg;
  assign bus.issue_count = count_reg;
endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Directed bench for rs_issue_scheduler: a vector table for per-cycle selection plus
// hand-written sequences for reset, repeat-issue blocking and issue_count wrap.
module tb_rs_issue_scheduler;
  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  rs_issue_scheduler_if #(.NUM_RS(64), .IDX_W(6)) bus ();

  rs_issue_scheduler #(.NUM_RS(64), .IDX_W(6), .ALU_LAT(1), .MEM_LAT(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] valid;
    logic [63:0] ready;
    logic [63:0] is_mem;
    logic        fl;
    logic        st;
    logic [2:0]  iv;
    logic [5:0]  i0;
    logic [5:0]  i1;
    logic [5:0]  i2;
    logic [63:0] clr;
    logic [2:0]  busy;
  } vec_t;

  localparam int NV = 13;
  vec_t tbl [NV];

  function automatic logic [63:0] bm(input int a);
    logic [63:0] one;
    one = 64'd1;
    return one << a;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input logic [63:0] v, input logic [63:0] r, input logic [63:0] m,
                       input logic fl, input logic st);
    bus.rs_valid  = v;
    bus.rs_ready  = r;
    bus.rs_is_mem = m;
    bus.flush     = fl;
    bus.mem_stall = st;
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int n, input logic [63:0] v, input logic [63:0] r,
                         input logic [63:0] m, input logic fl, input logic st,
                         input logic [2:0] iv, input logic [5:0] i0, input logic [5:0] i1,
                         input logic [5:0] i2, input logic [63:0] clr, input logic [2:0] busy);
    tbl[n].valid = v;   tbl[n].ready = r;  tbl[n].is_mem = m;
    tbl[n].fl    = fl;  tbl[n].st    = st;
    tbl[n].iv    = iv;  tbl[n].i0    = i0; tbl[n].i1 = i1; tbl[n].i2 = i2;
    tbl[n].clr   = clr; tbl[n].busy  = busy;
  endtask

  initial begin
    logic [63:0] s0, s1, s2, s3, s4;
    int hits7;

    s0 = bm(5) | bm(9) | bm(12);
    set_vec(0,  s0, s0, 64'd0, 0, 0, 3'b011, 5,  9, 0, bm(5) | bm(9), 3'b000);
    set_vec(1,  s0, s0, 64'd0, 0, 0, 3'b001, 12, 9, 0, bm(12), 3'b000);
    set_vec(2,  bm(61) | bm(30), bm(61), 64'd0, 0, 0, 3'b001, 61, 9, 0, bm(61), 3'b000);
    s1 = bm(63) | bm(1);
    set_vec(3,  s1, s1, 64'd0, 0, 0, 3'b011, 63, 1, 0, s1, 3'b000);
    s2 = bm(0) | bm(3);
    set_vec(4,  s2, s2, 64'd0, 0, 0, 3'b011, 3, 0, 0, s2, 3'b000);
    set_vec(5,  64'd0, 64'd0, 64'd0, 0, 0, 3'b000, 3, 0, 0, 64'd0, 3'b000);
    s3 = bm(3) | bm(4);
    set_vec(6,  s3, s3, s3, 0, 0, 3'b100, 3, 0, 3, bm(3), 3'b100);
    set_vec(7,  s3, s3, s3, 0, 0, 3'b000, 3, 0, 3, 64'd0, 3'b100);
    set_vec(8,  s3, s3, s3, 0, 0, 3'b000, 3, 0, 3, 64'd0, 3'b000);
    set_vec(9,  s3, s3, s3, 0, 1, 3'b000, 3, 0, 3, 64'd0, 3'b000);
    set_vec(10, s3, s3, s3, 0, 0, 3'b100, 3, 0, 4, bm(4), 3'b100);
    set_vec(11, bm(3) | bm(20), bm(3) | bm(20), bm(3), 1, 1, 3'b000, 3, 0, 4, 64'd0, 3'b000);
    s4 = bm(0) | bm(2) | bm(6) | bm(20);
    set_vec(12, s4, s4, bm(2) | bm(6), 0, 0, 3'b111, 20, 0, 6, bm(0) | bm(6) | bm(20), 3'b100);

    // Reset held with every input asserted.
    rst_n = 1'b0;
    bus.rs_valid = '1; bus.rs_ready = '1; bus.rs_is_mem = '1;
    bus.flush = 1'b1;  bus.mem_stall = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_issue_valid", 64'(bus.issue_valid), 64'd0);
    chk("rst_idx0",        64'(bus.issue_idx0),  64'd0);
    chk("rst_idx1",        64'(bus.issue_idx1),  64'd0);
    chk("rst_idx2",        64'(bus.issue_idx2),  64'd0);
    chk("rst_rs_clear",    bus.rs_clear,         64'd0);
    chk("rst_fu_busy",     64'(bus.fu_busy),     64'd0);
    chk("rst_issue_count", 64'(bus.issue_count), 64'd0);
    $display("reset: iv=%b clear=%h busy=%b cnt=%0d", bus.issue_valid, bus.rs_clear,
             bus.fu_busy, bus.issue_count);
    rst_n = 1'b1;

    for (int n = 0; n < NV; n++) begin
      apply(tbl[n].valid, tbl[n].ready, tbl[n].is_mem, tbl[n].fl, tbl[n].st);
      $display("vec %0d: iv=%b idx=%0d/%0d/%0d clear=%h busy=%b cnt=%0d", n, bus.issue_valid,
               bus.issue_idx0, bus.issue_idx1, bus.issue_idx2, bus.rs_clear, bus.fu_busy,
               bus.issue_count);
      chk($sformatf("v%0d_issue_valid", n), 64'(bus.issue_valid), 64'(tbl[n].iv));
      chk($sformatf("v%0d_idx0", n),        64'(bus.issue_idx0),  64'(tbl[n].i0));
      chk($sformatf("v%0d_idx1", n),        64'(bus.issue_idx1),  64'(tbl[n].i1));
      chk($sformatf("v%0d_idx2", n),        64'(bus.issue_idx2),  64'(tbl[n].i2));
      chk($sformatf("v%0d_rs_clear", n),    bus.rs_clear,         tbl[n].clr);
      chk($sformatf("v%0d_fu_busy", n),     64'(bus.fu_busy),     64'(tbl[n].busy));
    end
    chk("table_issue_count", 64'(bus.issue_count), 64'd13);

    // Entry 7 stays valid for two cycles after its select: must issue exactly once.
    hits7 = 0;
    for (int c = 0; c < 3; c++) begin
      apply((c < 2) ? bm(7) : 64'd0, (c < 2) ? bm(7) : 64'd0, 64'd0, 0, 0);
      $display("e7 cycle %0d: iv=%b idx0=%0d clear=%h", c, bus.issue_valid, bus.issue_idx0,
               bus.rs_clear);
      if (bus.rs_clear[7]) hits7++;
      if (c == 0) chk("e7_first_idx0", 64'(bus.issue_idx0), 64'd7);
      else        chk($sformatf("e7_c%0d_issue_valid", c), 64'(bus.issue_valid), 64'd0);
    end
    chk("e7_issued_once", 64'(hits7), 64'd1);
    chk("e7_issue_count", 64'(bus.issue_count), 64'd14);

    // Four ALU entries rotate two-per-cycle; 32760 cycles bring the count to 0xFFFE.
    s0 = bm(10) | bm(11) | bm(12) | bm(13);
    bus.rs_valid = s0; bus.rs_ready = s0; bus.rs_is_mem = 64'd0;
    bus.flush = 1'b0;  bus.mem_stall = 1'b0;
    repeat (32760) @(posedge clk);
    #1;
    $display("bulk: cnt=%h", bus.issue_count);
    chk("bulk_issue_count", 64'(bus.issue_count), 64'hFFFE);
    apply(bm(40), bm(40), 64'd0, 0, 0);
    $display("wrap step 1: idx0=%0d cnt=%h", bus.issue_idx0, bus.issue_count);
    chk("cnt_ffff", 64'(bus.issue_count), 64'hFFFF);
    apply(bm(41), bm(41), 64'd0, 0, 0);
    $display("wrap step 2: idx0=%0d cnt=%h", bus.issue_idx0, bus.issue_count);
    chk("cnt_wrap_zero", 64'(bus.issue_count), 64'h0000);
    chk("wrap_idx0", 64'(bus.issue_idx0), 64'd41);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
